// File: rtl/mips_fetch_pkg.sv
// Shared fetch definitions: state encoding, word geometry and the PC legality check.
package mips_fetch_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  localparam int INSTR_W = 32;
  localparam int WORD_BYTES = 4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  // A PC is fetchable only when word-aligned and inside the ROM.
  function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] limit);
    return (pc[1:0] == 2'b00) && (pc < limit);
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch/stall event counters; one cycle to update, never stalls the pipe.
// Fetch count freezes outside RUN, stall count always runs; both wrap at 2^32.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        accept,
  input  logic        stall,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (run && accept) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall)         stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer for a combinational ROM with a one-entry valid/ready output buffer; 1-cycle fetch latency,
// PC holds under backpressure. Optional perf counters when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter int          ROM_DEPTH = 32,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
`endif
  output logic               fault
);

  localparam logic [31:0] PC_LIMIT = 32'(ROM_DEPTH * WORD_BYTES);

  state_t      state;
  logic [31:0] pc;
  logic        slot_free;

  assign imem_addr = pc;
  assign slot_free = !instr_valid || instr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= ST_RUN;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_pc    <= 32'h0;
      fault       <= 1'b0;
    end else if (redirect_valid) begin
      // Buffered word is squashed even when decode takes it this cycle.
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
      if (pc_legal(redirect_pc, PC_LIMIT)) begin
        state <= ST_RUN;
        fault <= 1'b0;
      end else begin
        state <= ST_FAULT;
        fault <= 1'b1;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (slot_free) begin
            if (pc_legal(pc, PC_LIMIT)) begin
              instr       <= imem_data;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 32'(WORD_BYTES);
            end else begin
              // Any held word was just accepted, so the buffer empties here.
              instr_valid <= 1'b0;
              state       <= ST_FAULT;
              fault       <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          if (instr_valid && instr_ready) instr_valid <= 1'b0;
        end
        default: begin
          state <= ST_FAULT;
          fault <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state == ST_RUN),
    .accept    (instr_valid && instr_ready),
    .stall     (instr_valid && !instr_ready),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: ROM word at byte address 4k is 32'hC0DE_0000 + k.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'hC0DE_0000 + {2'b00, imem_addr[31:2]};

  fetch_ctrl #(.ROM_DEPTH(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .fault          (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    // Streaming with decode always ready.
    rst_n = 1'b1;
    tick();
    chk("first_valid", {31'b0, instr_valid}, 32'd1);
    chk("first_pc", instr_pc, 32'h0);
    chk("first_instr", instr, 32'hC0DE_0000);
    chk("first_addr", imem_addr, 32'h4);
    tick();
    chk("seq_pc4", instr_pc, 32'h4);
    tick();
    chk("seq_pc8", instr_pc, 32'h8);
    chk("seq_instr8", instr, 32'hC0DE_0002);
    chk("seq_addr12", imem_addr, 32'hC);

    // Backpressure for three cycles.
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", {31'b0, instr_valid}, 32'd1);
      chk("bp_pc", instr_pc, 32'h8);
      chk("bp_instr", instr, 32'hC0DE_0002);
      chk("bp_addr", imem_addr, 32'hC);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall3", perf_stall_cnt, 32'd3);
    chk("perf_fetch2", perf_fetch_cnt, 32'd2);
`endif

    // Redirect while a word is buffered and accepted the same cycle.
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("redir_squash", {31'b0, instr_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_fault", {31'b0, fault}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch3", perf_fetch_cnt, 32'd3);
`endif
    tick();
    chk("redir_valid", {31'b0, instr_valid}, 32'd1);
    chk("redir_pc", instr_pc, 32'h40);
    chk("redir_instr", instr, 32'hC0DE_0010);

    // Misaligned redirect faults and halts fetching.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_valid", {31'b0, instr_valid}, 32'd0);
    chk("mis_addr", imem_addr, 32'h42);
    tick();
    tick();
    chk("mis_hold_fault", {31'b0, fault}, 32'd1);
    chk("mis_hold_valid", {31'b0, instr_valid}, 32'd0);
    chk("mis_hold_addr", imem_addr, 32'h42);

    // Legal redirect recovers.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    chk("rec_fault", {31'b0, fault}, 32'd0);
    chk("rec_addr", imem_addr, 32'h10);
    tick();
    chk("rec_pc", instr_pc, 32'h10);
    chk("rec_instr", instr, 32'hC0DE_0004);
    chk("rec_valid", {31'b0, instr_valid}, 32'd1);

    // Run to the end of the 32-word ROM.
    for (int i = 1; i <= 27; i++) begin
      tick();
      chk("run_pc", instr_pc, 32'h10 + 32'(4 * i));
    end
    chk("end_instr", instr, 32'hC0DE_001F);
    chk("end_addr", imem_addr, 32'h80);
    chk("end_fault_pre", {31'b0, fault}, 32'd0);
    tick();
    chk("oor_fault", {31'b0, fault}, 32'd1);
    chk("oor_valid", {31'b0, instr_valid}, 32'd0);
    chk("oor_last_pc", instr_pc, 32'h7C);
    chk("oor_addr", imem_addr, 32'h80);
    tick();
    chk("oor_hold_addr", imem_addr, 32'h80);
    chk("oor_hold_valid", {31'b0, instr_valid}, 32'd0);

    // Reset while a word is held under backpressure.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    tick();
    chk("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
    chk("pre_rst_addr", imem_addr, 32'h4);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_pc", instr_pc, 32'h0);
    chk("mid_rst_fault", {31'b0, fault}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_pfetch", perf_fetch_cnt, 32'd0);
    chk("mid_rst_pstall", perf_stall_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
